// File: rtl/dpbram_rmw_port.sv
// Adapts byte-enabled load/store requests to the word-only BRAM port 1.
// Partial stores become a read of the old word followed by a merged write.
module dpbram_rmw_port #(
  parameter int RAM_ADDRWIDTH = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_we,
  input  logic [RAM_ADDRWIDTH+1:0] i_req_addr,
  input  logic [31:0]              i_req_wdata,
  input  logic [3:0]               i_req_be,
  output logic                     o_rsp_valid,
  output logic [31:0]              o_rsp_rdata,
  output logic                     o_ram_en,
  output logic                     o_ram_we,
  output logic [RAM_ADDRWIDTH-1:0] o_ram_addr,
  output logic [31:0]              o_ram_wd,
  input  logic [31:0]              i_ram_rd
);

  typedef enum logic [1:0] {IDLE, RD_RSP, MERGE, WR_ACK} state_t;

  state_t                   state_q, state_d;
  logic [RAM_ADDRWIDTH-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               be_q, be_d;
  logic [RAM_ADDRWIDTH-1:0] req_word;
  logic                     unused_addr_lsb;

  assign req_word        = i_req_addr[RAM_ADDRWIDTH+1:2];
  assign unused_addr_lsb = ^i_req_addr[1:0];

  function automatic logic [31:0] merge_lanes(input logic [31:0] new_w,
                                              input logic [31:0] old_w,
                                              input logic [3:0]  be);
    logic [31:0] m;
    for (int k = 0; k < 4; k++)
      m[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return m;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = '0;
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wd    = '0;
    unique case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (!i_req_we) begin
            o_ram_en   = 1'b1;
            o_ram_addr = req_word;
            state_d    = RD_RSP;
          end else if (i_req_be == 4'b1111) begin
            o_ram_en   = 1'b1;
            o_ram_we   = 1'b1;
            o_ram_addr = req_word;
            o_ram_wd   = i_req_wdata;
            state_d    = WR_ACK;
          end else if (i_req_be == 4'b0000) begin
            state_d    = WR_ACK;
          end else begin
            // Partial store: fetch the old word now, merge next cycle.
            o_ram_en   = 1'b1;
            o_ram_addr = req_word;
            addr_d     = req_word;
            wdata_d    = i_req_wdata;
            be_d       = i_req_be;
            state_d    = MERGE;
          end
        end
      end
      RD_RSP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = i_ram_rd;
        state_d     = IDLE;
      end
      MERGE: begin
        o_ram_en   = 1'b1;
        o_ram_we   = 1'b1;
        o_ram_addr = addr_q;
        o_ram_wd   = merge_lanes(wdata_q, i_ram_rd, be_q);
        state_d    = WR_ACK;
      end
      WR_ACK: begin
        o_rsp_valid = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dpbram_rmw_port.sv
// Bench for dpbram_rmw_port: BRAM model on port 1, transaction-level reference
// model checked every cycle, directed scenarios plus randomized traffic.
module tb_dpbram_rmw_port;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_be;
  logic          req_ready, rsp_valid, ram_en, ram_we;
  logic [31:0]   rsp_rdata, ram_wd;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rd = '0;

  logic [31:0] ram [512] = '{default: 32'h0};
  logic [31:0] ref_mem [512] = '{default: 32'h0};

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] last_rd = '0;
  int n_rsp = 0;

  dpbram_rmw_port #(.RAM_ADDRWIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wd(ram_wd), .i_ram_rd(ram_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wd;
      else        ram_rd <= ram[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: accepted request fixes the whole future of the transaction.
  int          busy_until = 0;
  bit          pend_rsp = 0, pend_merge = 0;
  int          rsp_cyc, merge_cyc;
  logic [31:0] rsp_data, m_wdata;
  logic [3:0]  m_be;
  int          m_word;

  always @(negedge clk) begin
    logic        e_ready, e_en, e_we, e_rv;
    logic [31:0] e_wd, e_rd, merged;
    int          e_addr, w;
    if (rsp_valid) begin
      last_rd = rsp_rdata;
      n_rsp++;
    end
    if (!rst_n) begin
      pend_rsp   = 0;
      pend_merge = 0;
      busy_until = cyc;
      chk("rst_en", {31'b0, ram_en}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end else begin
      e_ready = (cyc > busy_until);
      e_en = 0; e_we = 0; e_addr = 0; e_wd = '0; e_rv = 0; e_rd = '0;
      if (pend_rsp && cyc == rsp_cyc) begin
        e_rv = 1; e_rd = rsp_data; pend_rsp = 0;
      end
      if (pend_merge && cyc == merge_cyc) begin
        for (int k = 0; k < 4; k++)
          merged[8*k +: 8] = m_be[k] ? m_wdata[8*k +: 8] : ref_mem[m_word][8*k +: 8];
        e_en = 1; e_we = 1; e_addr = m_word; e_wd = merged;
        ref_mem[m_word] = merged;
        pend_merge = 0;
      end
      if (e_ready && req_valid) begin
        w = int'(req_addr >> 2);
        pend_rsp = 1;
        rsp_cyc  = cyc + 1;
        rsp_data = '0;
        if (!req_we) begin
          e_en = 1; e_addr = w;
          rsp_data = ref_mem[w];
        end else if (req_be == 4'hF) begin
          e_en = 1; e_we = 1; e_addr = w; e_wd = req_wdata;
          ref_mem[w] = req_wdata;
        end else if (req_be != 4'h0) begin
          e_en = 1; e_addr = w;
          pend_merge = 1; merge_cyc = cyc + 1;
          m_word = w; m_wdata = req_wdata; m_be = req_be;
          rsp_cyc = cyc + 2;
        end
        busy_until = rsp_cyc;
      end
      chk("ready", {31'b0, req_ready}, {31'b0, e_ready});
      chk("ram_en", {31'b0, ram_en}, {31'b0, e_en});
      if (e_en) begin
        chk("ram_we", {31'b0, ram_we}, {31'b0, e_we});
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_we) chk("ram_wd", ram_wd, e_wd);
      end
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
      if (e_rv) chk("rsp_rdata", rsp_rdata, e_rd);
    end
  end

  // Present a request and hold it until the DUT takes it (bounded).
  task automatic issue(input logic we, input logic [AW+1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    bit ok = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int rsp0;
    rst_n = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(2);

    issue(1, 11'h010, 32'hDEADBEEF, 4'hF); idle(2);
    issue(0, 11'h010, 32'h0, 4'h0); idle(2);
    chk("load_deadbeef", last_rd, 32'hDEADBEEF);
    chk("ram4_full", ram[4], 32'hDEADBEEF);

    issue(1, 11'h010, 32'h00000055, 4'b0001); idle(3);
    chk("ram4_be0001", ram[4], 32'hDEADBE55);
    issue(1, 11'h012, 32'hAABB0000, 4'b1100); idle(3);
    chk("ram4_be1100", ram[4], 32'hAABBBE55);

    rsp0 = n_rsp;
    issue(1, 11'h010, 32'h12345678, 4'b0000); idle(3);
    chk("ram4_be0000", ram[4], 32'hAABBBE55);
    chk("empty_store_rsp", 32'(n_rsp - rsp0), 32'd1);

    issue(1, 11'h01C, 32'h11223344, 4'hF); idle(2);
    rsp0 = n_rsp;
    issue(1, 11'h01C, 32'h0000FF00, 4'b0010);
    #1 rst_n = 0;
    idle(2);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    idle(2);
    chk("ram7_abandoned", ram[7], 32'h11223344);
    chk("no_rsp_in_rst", 32'(n_rsp - rsp0), 32'd0);

    // Held-valid back-to-back: the next request is presented the cycle after acceptance.
    issue(0, 11'h01C, 32'h0, 4'h0);
    issue(1, 11'h010, 32'h00CC0000, 4'b0100);
    issue(0, 11'h010, 32'h0, 4'h0);
    idle(3);
    chk("b2b_load", last_rd, 32'hAACCBE55);

    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1);
      req_addr  = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 63));
      req_wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       req_be = 4'hF;
        1:       req_be = 4'h0;
        default: req_be = 4'($urandom);
      endcase
      idle(1);
    end
    req_valid = 0;
    idle(4);
    for (int k = 0; k < 512; k++)
      if (ram[k] !== ref_mem[k]) chk("final_ram", ram[k], ref_mem[k]);
    n_checks++;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
